// File: rtl/ghost_typist_if.sv
// Key-event bus between a keystroke source (ghost typist or keyboard decoder) and its consumer.
// The master drives the word request; the slave drives key events and status.
interface ghost_typist_if;
  logic         start;
  logic         abort;
  logic [74:0]  word;
  logic [4:0]   wordnum;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, word, wordnum,
    input  key_down, last_change, key_valid, busy, done
  );

  modport slave (
    input  start, abort, word, wordnum,
    output key_down, last_change, key_valid, busy, done
  );
endinterface

// File: rtl/ghost_typist.sv
// Synthetic keyboard replaying one latched word as press/hold/release/gap events, then SPACE; first press 1 tick after start.
// No backpressure: events are fire-and-forget pulses. Define GHOST_TYPO_EN for LFSR-driven mistype + BACK correction.
module ghost_typist #(
  parameter int HOLD_TICKS = 3,
  parameter int GAP_TICKS  = 5
) (
  input  logic          clk_div,
  input  logic          rst,
  ghost_typist_if.slave bus
);

  localparam int MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CW   = (MAXT < 1) ? 1 : $clog2(MAXT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [6:0] SPACE_CODE = 7'd41;
  localparam logic [6:0] BACK_CODE  = 7'd102;

  typedef enum logic [2:0] {IDLE, PRESS, HOLD, RELEASE, GAP, DONE} state_t;

  function automatic logic [6:0] scan_code(input logic [4:0] v);
    case (v)
      5'd1:  scan_code = 7'd28;  5'd2:  scan_code = 7'd50;  5'd3:  scan_code = 7'd33;
      5'd4:  scan_code = 7'd35;  5'd5:  scan_code = 7'd36;  5'd6:  scan_code = 7'd43;
      5'd7:  scan_code = 7'd52;  5'd8:  scan_code = 7'd51;  5'd9:  scan_code = 7'd67;
      5'd10: scan_code = 7'd59;  5'd11: scan_code = 7'd66;  5'd12: scan_code = 7'd75;
      5'd13: scan_code = 7'd58;  5'd14: scan_code = 7'd49;  5'd15: scan_code = 7'd68;
      5'd16: scan_code = 7'd77;  5'd17: scan_code = 7'd21;  5'd18: scan_code = 7'd45;
      5'd19: scan_code = 7'd27;  5'd20: scan_code = 7'd44;  5'd21: scan_code = 7'd60;
      5'd22: scan_code = 7'd42;  5'd23: scan_code = 7'd29;  5'd24: scan_code = 7'd34;
      5'd25: scan_code = 7'd53;  5'd26: scan_code = 7'd26;
      default: scan_code = SPACE_CODE;
    endcase
  endfunction

  // First typeable letter at or after 'from'; returns n (the SPACE slot) if none remain.
  function automatic logic [3:0] next_slot(input logic [74:0] w, input logic [3:0] n,
                                           input logic [3:0] from);
    logic [3:0] r;
    logic       found;
    r     = n;
    found = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (!found && 4'(j) >= from && 4'(j) < n &&
          w[5*j +: 5] != 5'd0 && w[5*j +: 5] <= 5'd26) begin
        r     = 4'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     idx, idx_nxt, n_lat, n_nxt, slot;
  logic [74:0]    word_lat, word_nxt;
  logic [6:0]     last_reg, cur_code;
  logic [4:0]     cur_v;
  logic           is_space, adv, pick, in_typo;

`ifdef GHOST_TYPO_EN
  typedef enum logic [1:0] {PH_NORM, PH_WRONG, PH_BACK} phase_t;
  phase_t     phase, phase_nxt;
  logic [7:0] lfsr, lfsr_nxt;
  assign in_typo = (phase != PH_NORM);
`else
  assign in_typo = 1'b0;
`endif

  always_comb begin
    cur_v = 5'd0;
    for (int j = 0; j < 15; j++) begin
      if (idx == 4'(j)) cur_v = word_lat[5*j +: 5];
    end
  end

  assign is_space = (idx == n_lat);

  always_comb begin
    cur_code = is_space ? SPACE_CODE : scan_code(cur_v);
`ifdef GHOST_TYPO_EN
    if (phase == PH_WRONG)     cur_code = scan_code((cur_v == 5'd26) ? 5'd1 : cur_v + 5'd1);
    else if (phase == PH_BACK) cur_code = BACK_CODE;
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    n_nxt     = n_lat;
    word_nxt  = word_lat;
    slot      = 4'd0;
    adv       = 1'b0;
    pick      = 1'b0;
`ifdef GHOST_TYPO_EN
    phase_nxt = phase;
    lfsr_nxt  = lfsr;
`endif
    if (bus.abort) begin
      state_nxt = IDLE;
      idx_nxt   = 4'd0;
`ifdef GHOST_TYPO_EN
      phase_nxt = PH_NORM;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start && bus.wordnum != 5'd0) begin
          word_nxt = bus.word;
          n_nxt    = (bus.wordnum > 5'd15) ? 4'd15 : bus.wordnum[3:0];
          slot     = next_slot(bus.word, n_nxt, 4'd0);
          pick     = 1'b1;
        end
        PRESS: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
        HOLD: if (cnt == HOLD_LAST) state_nxt = RELEASE;
              else                  cnt_nxt   = cnt + CW'(1);
        RELEASE: if (GAP_TICKS == 0) adv = 1'b1;
                 else begin
                   state_nxt = GAP;
                   cnt_nxt   = '0;
                 end
        GAP: if (cnt == GAP_LAST) adv     = 1'b1;
             else                 cnt_nxt = cnt + CW'(1);
        DONE: begin
          state_nxt = IDLE;
          idx_nxt   = 4'd0;
        end
        default: state_nxt = IDLE;
      endcase

      if (adv) begin
        if (in_typo) begin
          state_nxt = PRESS;
`ifdef GHOST_TYPO_EN
          phase_nxt = (phase == PH_WRONG) ? PH_BACK : PH_NORM;
`endif
        end else if (is_space) begin
          state_nxt = DONE;
        end else begin
          slot = next_slot(word_lat, n_lat, idx + 4'd1);
          pick = 1'b1;
        end
      end

      if (pick) begin
        state_nxt = PRESS;
        idx_nxt   = slot;
`ifdef GHOST_TYPO_EN
        // SPACE never gets a typo and does not consume an LFSR step.
        if (slot != n_nxt) begin
          lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          phase_nxt = (lfsr[2:0] == 3'd0) ? PH_WRONG : PH_NORM;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= 4'd0;
      n_lat    <= 4'd0;
      word_lat <= '0;
      last_reg <= 7'd0;
`ifdef GHOST_TYPO_EN
      phase    <= PH_NORM;
      lfsr     <= 8'hA5;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      n_lat    <= n_nxt;
      word_lat <= word_nxt;
      if (bus.key_valid) last_reg <= cur_code;
`ifdef GHOST_TYPO_EN
      phase    <= phase_nxt;
      lfsr     <= lfsr_nxt;
`endif
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.key_valid   = (state == PRESS) || (state == RELEASE);
  assign bus.key_down    = (state == PRESS || state == HOLD) ? (128'd1 << cur_code) : '0;
  assign bus.last_change = {2'b00, bus.key_valid ? cur_code : last_reg};

endmodule

// File: tb/tb_ghost_typist.sv
`timescale 1ns/1ps
module tb_ghost_typist;
  localparam int H = 3;
  localparam int G = 5;
  localparam int P = H + G + 2;

  typedef struct {
    int kind;   // 0 press, 1 release, 2 done
    int code;
    int cyc;
  } ev_t;

  logic clk_div = 1'b0;
  logic rst;
  ghost_typist_if bus ();

  ghost_typist #(.HOLD_TICKS(H), .GAP_TICKS(G)) dut (
    .clk_div (clk_div),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_div = ~clk_div;

  int  letter_code [27] = '{0, 28, 50, 33, 35, 36, 43, 52, 51, 67, 59, 66, 75, 58, 49,
                            68, 77, 21, 45, 27, 44, 60, 42, 29, 34, 53, 26};
  ev_t q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  busy_lo  = 1;
  int  busy_hi  = 0;
  bit  mon_en   = 1'b0;

  always @(posedge clk_div) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int code, input int t);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.cyc  = t;
    q.push_back(e);
  endtask

  // Reference: valid letters in order, then SPACE, each occupying one char period; done after the last gap.
  task automatic expect_word(input logic [74:0] w, input int wn, input int c);
    int t;
    int n;
    int v;
    t = c + 1;
    n = (wn > 15) ? 15 : wn;
    for (int i = 0; i < n; i++) begin
      v = int'(w[5*i +: 5]);
      if (v >= 1 && v <= 26) begin
        push(0, letter_code[v], t);
        push(1, letter_code[v], t + H + 1);
        t += P;
      end
    end
    push(0, 41, t);
    push(1, 41, t + H + 1);
    t += P;
    push(2, 0, t);
    busy_lo = c + 1;
    busy_hi = t;
  endtask

  always @(negedge clk_div) begin
    if (mon_en && !rst) begin
      ev_t e;
      int  kind;
      chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      chk("onehot", ($countones(bus.key_down) <= 1) ? 1 : 0, 1);
      if (bus.key_valid || bus.done) begin
        kind = bus.done ? 2 : ((bus.key_down != '0) ? 0 : 1);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got kind %0d code %0d, expected none (cycle %0d)",
                   kind, bus.last_change, cyc);
        end else begin
          e = q.pop_front();
          chk("evt_kind", kind, e.kind);
          chk("evt_cycle", cyc, e.cyc);
          if (e.kind < 2) chk("evt_code", bus.last_change, e.code);
          if (e.kind == 0) chk("press_bitmap", (bus.key_down == (128'd1 << e.code)) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic launch(input logic [74:0] w, input int wn, input int hold);
    @(posedge clk_div);
    #1;
    bus.word    = w;
    bus.wordnum = wn[4:0];
    bus.start   = 1'b1;
    if (wn != 0) expect_word(w, wn, cyc);
    else begin
      busy_lo = 1;
      busy_hi = 0;
    end
    repeat (hold) @(posedge clk_div);
    #1;
    bus.start = 1'b0;
    bus.word  = {$urandom, $urandom, $urandom};
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk_div);
      n++;
    end
    chk("drain_in_budget", (n < budget) ? 1 : 0, 1);
    repeat (3) @(negedge clk_div);
  endtask

  function automatic logic [74:0] mk3(input int a, input int b, input int c);
    logic [74:0] w;
    w = '0;
    w[4:0]   = a[4:0];
    w[9:5]   = b[4:0];
    w[14:10] = c[4:0];
    return w;
  endfunction

  initial begin
    logic [74:0] w;
    int          wn;
    int          c;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.word    = '0;
    bus.wordnum = 5'd0;
    #12;
    chk("rst_key_down", (bus.key_down == '0) ? 1 : 0, 1);
    chk("rst_last_change", bus.last_change, 0);
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk_div);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    // CAT, with start held into the busy period
    launch(mk3(3, 1, 20), 3, 6);
    drain(200);

    // invalid middle letter is skipped without consuming a slot
    launch(mk3(3, 27, 20), 3, 1);
    drain(200);

    // wordnum = 0 never leaves IDLE
    launch(mk3(3, 1, 20), 0, 1);
    repeat (5) @(negedge clk_div);
    chk("wordnum0_idle", bus.busy, 0);

    // abort during HOLD of C
    @(posedge clk_div);
    #1;
    bus.word    = mk3(3, 1, 20);
    bus.wordnum = 5'd3;
    bus.start   = 1'b1;
    c           = cyc;
    push(0, 33, c + 1);
    busy_lo = c + 1;
    busy_hi = c + 3;
    @(posedge clk_div);
    #1 bus.start = 1'b0;
    @(posedge clk_div);
    @(posedge clk_div);
    #1 bus.abort = 1'b1;
    @(posedge clk_div);
    #1 bus.abort = 1'b0;
    chk("abort_key_down", (bus.key_down == '0) ? 1 : 0, 1);
    chk("abort_busy", bus.busy, 0);
    repeat (30) @(negedge clk_div);
    chk("abort_queue_empty", q.size(), 0);

    // asynchronous reset during HOLD, then a clean replay
    @(posedge clk_div);
    #1;
    bus.word    = mk3(3, 1, 20);
    bus.wordnum = 5'd3;
    bus.start   = 1'b1;
    c           = cyc;
    push(0, 33, c + 1);
    busy_lo = c + 1;
    busy_hi = c + 2;
    @(posedge clk_div);
    #1 bus.start = 1'b0;
    @(posedge clk_div);
    #2 rst = 1'b1;
    #1;
    chk("arst_key_down", (bus.key_down == '0) ? 1 : 0, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_key_valid", bus.key_valid, 0);
    chk("arst_last_change", bus.last_change, 0);
    chk("arst_queue_empty", q.size(), 0);
    q.delete();
    busy_lo = 1;
    busy_hi = 0;
    repeat (2) @(posedge clk_div);
    #2 rst = 1'b0;
    launch(mk3(3, 1, 20), 3, 1);
    drain(200);

    // randomized words, including invalid letters and wordnum above 15
    for (int r = 0; r < 12; r++) begin
      w = '0;
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(0, 4) == 0) w[5*i +: 5] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(27, 31));
        else                           w[5*i +: 5] = 5'($urandom_range(1, 26));
      end
      wn = (r % 4 == 3) ? int'($urandom_range(16, 31)) : int'($urandom_range(1, 15));
      launch(w, wn, int'($urandom_range(1, 8)));
      drain(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
